// File: rtl/cmd_param_buffer.sv
// Telecommand parameter buffer: captures detector byte strobes into a register file,
// validates the frame at end-of-frame and holds it for the controller until acknowledged.
// Optional XOR checksum check is enabled by defining CMD_BUF_CHECKSUM_EN.
module cmd_param_buffer #(
    parameter int DEPTH      = 32,
    parameter int ADDR_W     = 5,
    parameter int EXP_WRITES = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              CMD_WCLK,
    input  logic [ADDR_W-1:0] CMD_WADDR,
    input  logic [7:0]        PARAM_Byte,
    input  logic              CMD_Detected,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              cmd_valid,
    output logic              cmd_err,
    input  logic              cmd_ack,
    output logic [5:0]        wr_count,
    output logic              overrun
);

    typedef enum logic [1:0] {COLLECT, CHECK, PRESENT} state_t;

    localparam logic [5:0] EXP_COUNT = 6'(EXP_WRITES);

    state_t     state_reg, state_next;
    logic       wclk_d_reg, det_d_reg;
    logic [5:0] wr_count_reg, wr_count_next;
    logic       cmd_valid_reg, cmd_valid_next;
    logic       cmd_err_reg, cmd_err_next;
    logic       overrun_reg, overrun_next;
    logic [7:0] rd_data_reg;
    logic [7:0] mem [DEPTH];

    logic wclk_rise, det_fall, mem_we, frame_release, checksum_fail;

    assign wclk_rise = CMD_WCLK & ~wclk_d_reg;
    assign det_fall  = ~CMD_Detected & det_d_reg;

    always_comb begin
        state_next     = state_reg;
        wr_count_next  = wr_count_reg;
        cmd_valid_next = cmd_valid_reg;
        cmd_err_next   = cmd_err_reg;
        overrun_next   = overrun_reg;
        mem_we         = 1'b0;
        frame_release  = 1'b0;
        case (state_reg)
            COLLECT: begin
                if (wclk_rise) begin
                    mem_we        = 1'b1;
                    wr_count_next = (wr_count_reg == 6'd63) ? 6'd63 : wr_count_reg + 6'd1;
                end
                // An end-of-frame with nothing captured is not a frame.
                if (det_fall && (wr_count_next != 6'd0)) begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                cmd_err_next   = (wr_count_reg != EXP_COUNT) | checksum_fail;
                cmd_valid_next = 1'b1;
                state_next     = PRESENT;
                if (wclk_rise) begin
                    overrun_next = 1'b1;
                end
            end
            PRESENT: begin
                // A strobe coinciding with the release is dropped silently.
                if (cmd_ack) begin
                    cmd_valid_next = 1'b0;
                    cmd_err_next   = 1'b0;
                    wr_count_next  = 6'd0;
                    overrun_next   = 1'b0;
                    frame_release  = 1'b1;
                    state_next     = COLLECT;
                end else if (wclk_rise) begin
                    overrun_next = 1'b1;
                end
            end
            default: begin
                state_next = COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= COLLECT;
            wclk_d_reg    <= 1'b0;
            det_d_reg     <= 1'b0;
            wr_count_reg  <= 6'd0;
            cmd_valid_reg <= 1'b0;
            cmd_err_reg   <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wclk_d_reg    <= CMD_WCLK;
            det_d_reg     <= CMD_Detected;
            wr_count_reg  <= wr_count_next;
            cmd_valid_reg <= cmd_valid_next;
            cmd_err_reg   <= cmd_err_next;
            overrun_reg   <= overrun_next;
        end
    end

    // Register file contents survive reset; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (mem_we && reset) begin
            mem[CMD_WADDR] <= PARAM_Byte;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_data_reg <= 8'h00;
        end else begin
            rd_data_reg <= mem[rd_addr];
        end
    end

`ifdef CMD_BUF_CHECKSUM_EN
    logic [7:0] acc_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_reg <= 8'h00;
        end else if (frame_release) begin
            acc_reg <= 8'h00;
        end else if (mem_we) begin
            acc_reg <= acc_reg ^ PARAM_Byte;
        end
    end

    // The sender's final byte makes the XOR over the whole frame zero.
    assign checksum_fail = (acc_reg != 8'h00);
`else
    assign checksum_fail = 1'b0;
`endif

    assign rd_data   = rd_data_reg;
    assign cmd_valid = cmd_valid_reg;
    assign cmd_err   = cmd_err_reg;
    assign wr_count  = wr_count_reg;
    assign overrun   = overrun_reg;

endmodule

// File: tb/tb_cmd_param_buffer.sv
// Scoreboard bench for cmd_param_buffer: stimulus pushes expected frame results and
// readback bytes into queues, an independent monitor pops and compares them.
module tb_cmd_param_buffer;

    logic       clk = 1'b0;
    logic       reset;
    logic       CMD_WCLK;
    logic [4:0] CMD_WADDR;
    logic [7:0] PARAM_Byte;
    logic       CMD_Detected;
    logic [4:0] rd_addr;
    logic [7:0] rd_data;
    logic       cmd_valid;
    logic       cmd_err;
    logic       cmd_ack;
    logic [5:0] wr_count;
    logic       overrun;

    always #5 clk = ~clk;

    cmd_param_buffer #(.DEPTH(32), .ADDR_W(5), .EXP_WRITES(32)) dut (
        .clk(clk), .reset(reset), .CMD_WCLK(CMD_WCLK), .CMD_WADDR(CMD_WADDR),
        .PARAM_Byte(PARAM_Byte), .CMD_Detected(CMD_Detected), .rd_addr(rd_addr),
        .rd_data(rd_data), .cmd_valid(cmd_valid), .cmd_err(cmd_err), .cmd_ack(cmd_ack),
        .wr_count(wr_count), .overrun(overrun)
    );

    typedef struct {int due; int addr; int data;} rd_exp_t;
    typedef struct {int count; int err;} frm_exp_t;

    rd_exp_t    rd_q[$];
    frm_exp_t   frm_q[$];
    logic [7:0] tb_mem [32];
    bit         tb_written [32];
    int         fa[$];
    logic [7:0] fd[$];
    int         nwrites;
    logic [7:0] xacc;
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    int         frame_no = 0;
    logic       mon_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Reference outcome of a frame from its write count and byte XOR.
    function automatic frm_exp_t expect_frame();
        frm_exp_t e;
        e.count = (nwrites > 63) ? 63 : nwrites;
        e.err   = (e.count != 32) ? 1 : 0;
`ifdef CMD_BUF_CHECKSUM_EN
        if (xacc != 8'h00) e.err = 1;
`endif
        return e;
    endfunction

    task automatic model_write(input int addr, input logic [7:0] data);
        tb_mem[addr]     = data;
        tb_written[addr] = 1'b1;
        nwrites++;
        xacc ^= data;
    endtask

    task automatic strobe(input int addr, input logic [7:0] data);
        CMD_WADDR  = 5'(addr);
        PARAM_Byte = data;
        CMD_WCLK   = 1'b1;
        tick();
        CMD_WCLK   = 1'b0;
        tick();
        model_write(addr, data);
    endtask

    task automatic read_check(input int addr);
        rd_exp_t r;
        rd_addr = 5'(addr);
        r.due   = cyc + 1;
        r.addr  = addr;
        r.data  = int'(tb_mem[addr]);
        rd_q.push_back(r);
        tick();
    endtask

    task automatic build_frame(input int n, input bit good);
        logic [7:0] x;
        logic [7:0] d;
        fa.delete();
        fd.delete();
        x = 8'h00;
        for (int i = 0; i < n; i++) begin
            fa.push_back(int'($urandom_range(0, 31)));
            if (good && i == n - 1) begin
                fd.push_back(x);
            end else begin
                d = 8'($urandom_range(0, 255));
                fd.push_back(d);
                x ^= d;
            end
        end
    endtask

    task automatic run_frame(input bit simul);
        frm_exp_t e;
        int n;
        n = fa.size();
        CMD_Detected = 1'b1;
        nwrites = 0;
        xacc = 8'h00;
        tick();
        for (int i = 0; i < n - 1; i++) strobe(fa[i], fd[i]);
        if (simul) begin
            CMD_WADDR    = 5'(fa[n-1]);
            PARAM_Byte   = fd[n-1];
            CMD_WCLK     = 1'b1;
            CMD_Detected = 1'b0;
            model_write(fa[n-1], fd[n-1]);
            frm_q.push_back(expect_frame());
            tick();
            CMD_WCLK = 1'b0;
        end else begin
            strobe(fa[n-1], fd[n-1]);
            frm_q.push_back(expect_frame());
            CMD_Detected = 1'b0;
            tick();
        end
        check("valid_too_early", int'(cmd_valid), 0);
        tick();
        check("valid_latency", int'(cmd_valid), 1);
        e = expect_frame();
        frame_no++;
        $display("frame %0d: writes=%0d simul=%0d exp_count=%0d exp_err=%0d dut_count=%0d dut_err=%0d",
                 frame_no, nwrites, simul, e.count, e.err, wr_count, cmd_err);
    endtask

    task automatic ack_frame();
        cmd_ack = 1'b1;
        tick();
        cmd_ack = 1'b0;
        check("ack_valid", int'(cmd_valid), 0);
        check("ack_err", int'(cmd_err), 0);
        check("ack_count", int'(wr_count), 0);
        check("ack_overrun", int'(overrun), 0);
    endtask

    task automatic read_some();
        for (int k = 0; k < 3; k++) begin
            int a;
            a = fa[$urandom_range(0, fa.size() - 1)];
            read_check(a);
        end
    endtask

    // Monitor: compares readback bytes when due and frame results when cmd_valid rises.
    initial begin
        forever begin
            @(negedge clk);
            while (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
                rd_exp_t r;
                r = rd_q.pop_front();
                check($sformatf("rd_data[%0d]", r.addr), int'(rd_data), r.data);
            end
            if (reset && cmd_valid && !mon_prev) begin
                if (frm_q.size() == 0) begin
                    check("unexpected_valid", int'(cmd_valid), 0);
                end else begin
                    frm_exp_t e;
                    e = frm_q.pop_front();
                    check("frame_count", int'(wr_count), e.count);
                    check("frame_err", int'(cmd_err), e.err);
                end
            end
            mon_prev = cmd_valid;
        end
    end

    initial begin
        logic [7:0] x;
        reset        = 1'b0;
        CMD_WCLK     = 1'b0;
        CMD_WADDR    = 5'd0;
        PARAM_Byte   = 8'h00;
        CMD_Detected = 1'b1;
        rd_addr      = 5'd0;
        cmd_ack      = 1'b0;
        for (int i = 0; i < 32; i++) begin
            tb_mem[i]     = 8'h00;
            tb_written[i] = 1'b0;
        end

        // Reset held with strobes toggling
        for (int i = 0; i < 3; i++) begin
            CMD_WCLK   = ~CMD_WCLK;
            CMD_WADDR  = 5'(i);
            PARAM_Byte = 8'hC0;
            tick();
        end
        check("rst_valid", int'(cmd_valid), 0);
        check("rst_err", int'(cmd_err), 0);
        check("rst_count", int'(wr_count), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_rd_data", int'(rd_data), 0);
        CMD_WCLK     = 1'b0;
        CMD_Detected = 1'b0;
        reset        = 1'b1;
        tick();
        tick();

        // End of frame with no writes is ignored
        CMD_Detected = 1'b1;
        tick();
        CMD_Detected = 1'b0;
        repeat (4) tick();
        check("empty_fall_valid", int'(cmd_valid), 0);

        // Directed good frame: addresses 1..31 then 0, data = address, addr0 = XOR of the rest
        fa.delete();
        fd.delete();
        x = 8'h00;
        for (int a = 1; a < 32; a++) begin
            fa.push_back(a);
            fd.push_back(8'(a));
            x ^= 8'(a);
        end
        fa.push_back(0);
        fd.push_back(x);
        run_frame(1'b0);
        read_check(5);
        // Locked frame: a strobe is dropped and flags overrun
        CMD_WADDR  = 5'd5;
        PARAM_Byte = 8'hAA;
        CMD_WCLK   = 1'b1;
        tick();
        CMD_WCLK   = 1'b0;
        tick();
        check("lock_overrun", int'(overrun), 1);
        check("lock_count", int'(wr_count), 32);
        read_check(5);
        ack_frame();
        read_check(5);

        // Directed frame with a corrupted checksum byte
        fd[31] = fd[31] ^ 8'h01;
        run_frame(1'b0);
        ack_frame();

        // Directed good frame with last strobe coinciding with the fall
        fd[31] = fd[31] ^ 8'h01;
        run_frame(1'b1);
        ack_frame();

        // Short frame; strobe in the same cycle as ack is dropped without overrun
        build_frame(20, 1'b0);
        run_frame(1'b0);
        read_some();
        CMD_WADDR  = 5'(fa[0]);
        PARAM_Byte = ~tb_mem[fa[0]];
        CMD_WCLK   = 1'b1;
        cmd_ack    = 1'b1;
        tick();
        CMD_WCLK   = 1'b0;
        cmd_ack    = 1'b0;
        check("ack_strobe_overrun", int'(overrun), 0);
        check("ack_strobe_valid", int'(cmd_valid), 0);
        check("ack_strobe_count", int'(wr_count), 0);
        tick();
        read_check(fa[0]);

        // Saturating count
        build_frame(70, 1'b0);
        run_frame(1'b0);
        ack_frame();

        // Randomized frames
        for (int f = 0; f < 10; f++) begin
            int kind;
            kind = int'($urandom_range(0, 3));
            case (kind)
                0: build_frame(32, 1'b1);
                1: build_frame(int'($urandom_range(1, 40)), 1'b0);
                2: build_frame(32, 1'b0);
                default: build_frame(int'($urandom_range(30, 34)), 1'b1);
            endcase
            run_frame(bit'($urandom_range(0, 1)));
            read_some();
            ack_frame();
        end

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 10 && rd_q.size() > 0; i++) tick();
        check("rd_pending", rd_q.size(), 0);
        check("frames_pending", frm_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
